ads41_idelay_autocal: RTL

//  Automatic per-lane IDELAY eye calibration for NCH ADS41-family ADC capture channels.
//  - While the ADCs drive a fixed test pattern, sweeps every data-lane IDELAY through all taps.
//  - Records pass/fail for each tap and finds the longest passing run per lane.
//  - Parks each lane's delay at the centre of its longest run.
//  - Sits beside the ADC capture front-ends and drives their IDELAY CE/INC/LD controls.

---
 rtl/ads41_cal_pkg.sv | 28 ++
 rtl/ads41_eye_tracker.sv | 74 +++++++
 rtl/ads41_idelay_autocal.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ads41_cal_pkg.sv
// Shared types and width helpers for the ADS41 IDELAY eye calibration block.
package ads41_cal_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StSettle,
        StCheck,
        StRecord,
        StStep,
        StReload,
        StMove,
        StFinish
    } cal_state_e;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int unsigned calc_tw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ads41_eye_tracker.sv
// Per-lane tracker of the current and longest passing tap run; reports the eye centre.
module ads41_eye_tracker
    import ads41_cal_pkg::*;
#(
    parameter int unsigned NTAPS   = 32,
    parameter int unsigned MIN_EYE = 4,
    localparam int unsigned TW     = calc_tw(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          record,
    input  logic          close,
    input  logic          pass,
    input  logic [TW-1:0] tap,
    output logic [TW-1:0] centre,
    output logic          fail
);

    localparam int unsigned LW = TW + 1;

    logic [LW-1:0] run_len_q, run_len_d, best_len_q, best_len_d;
    logic [TW-1:0] run_start_q, run_start_d, best_start_q, best_start_d;

    always_comb begin
        run_len_d    = run_len_q;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        if (clear) begin
            run_len_d    = '0;
            run_start_d  = '0;
            best_len_d   = '0;
            best_start_d = '0;
        end else if (record) begin
            if (pass) begin
                if (run_len_d == '0) run_start_d = tap;
                run_len_d = run_len_d + 1'b1;
            end else begin
                if (run_len_d > best_len_d) begin
                    best_len_d   = run_len_d;
                    best_start_d = run_start_d;
                end
                run_len_d = '0;
            end
            // Last tap: a run still open at the end of the sweep competes too.
            if (close) begin
                if (run_len_d > best_len_d) begin
                    best_len_d   = run_len_d;
                    best_start_d = run_start_d;
                end
                run_len_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
        end else begin
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
        end
    end

    assign centre = (best_len_q == '0) ? '0 : best_start_q + TW'(best_len_q >> 1);
    assign fail   = best_len_q < LW'(MIN_EYE);

endmodule

// File: rtl/ads41_idelay_autocal.sv
// Sweeps all data-lane IDELAYs against a fixed ADC test pattern and parks each lane at the
// centre of its widest passing window.
module ads41_idelay_autocal
    import ads41_cal_pkg::*;
#(
    parameter int unsigned      NCH        = 2,
    parameter int unsigned      NBITS      = 12,
    parameter int unsigned      NTAPS      = 32,
    parameter int unsigned      SETTLE_CYC = 16,
    parameter int unsigned      CHECK_CYC  = 256,
    parameter int unsigned      MIN_EYE    = 4,
    parameter logic [NBITS-1:0] TEST_WORD  = 12'hA5C,
    localparam int unsigned     L          = NCH * NBITS / 2,
    localparam int unsigned     TW         = calc_tw(NTAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NCH*NBITS-1:0] d_in,
    input  logic                 d_valid,
    output logic                 idelay_ld,
    output logic [L-1:0]         idelay_ce,
    output logic [L-1:0]         idelay_inc,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [L-1:0]         lane_fail,
    output logic [L*TW-1:0]      tap_out
);

    localparam int unsigned CW = calc_tw(max3(SETTLE_CYC, CHECK_CYC, NTAPS) + 1);

    cal_state_e      state_q, state_d;
    logic [TW-1:0]   tap_q, tap_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [L-1:0]    bad_q, bad_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [L-1:0]    lane_fail_q, lane_fail_d;
    logic [L*TW-1:0] tap_out_q, tap_out_d;

    logic            trk_clear, trk_record, trk_close;
    logic [L-1:0]    lane_bad, trk_fail, move_ce;
    logic [TW-1:0]   centre [L];

    for (genvar l = 0; l < L; l++) begin : g_lane
        localparam int unsigned LaneCh  = l / (NBITS / 2);
        localparam int unsigned LaneBit = 2 * (l % (NBITS / 2));

        assign lane_bad[l] = d_in[LaneCh*NBITS + LaneBit +: 2] != TEST_WORD[LaneBit +: 2];
        assign move_ce[l]  = 32'(cnt_q) < 32'(centre[l]);

        ads41_eye_tracker #(
            .NTAPS   (NTAPS),
            .MIN_EYE (MIN_EYE)
        ) u_tracker (
            .clk    (clk),
            .rst    (rst),
            .clear  (trk_clear),
            .record (trk_record),
            .close  (trk_close),
            .pass   (~bad_q[l]),
            .tap    (tap_q),
            .centre (centre[l]),
            .fail   (trk_fail[l])
        );
    end

    assign trk_close = tap_q == TW'(NTAPS - 1);

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        cnt_d       = cnt_q;
        bad_d       = bad_q;
        done_d      = 1'b0;
        err_d       = err_q;
        lane_fail_d = lane_fail_q;
        tap_out_d   = tap_out_q;
        trk_clear   = 1'b0;
        trk_record  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    trk_clear   = 1'b1;
                    err_d       = 1'b0;
                    lane_fail_d = '0;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                tap_d   = '0;
                cnt_d   = '0;
                state_d = StSettle;
            end
            StSettle: begin
                bad_d = '0;
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                if (d_valid) begin
                    bad_d = bad_q | lane_bad;
                    if (cnt_q == CW'(CHECK_CYC - 1)) begin
                        cnt_d   = '0;
                        state_d = StRecord;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRecord: begin
                trk_record = 1'b1;
                state_d    = trk_close ? StReload : StStep;
            end
            StStep: begin
                tap_d   = tap_q + 1'b1;
                cnt_d   = '0;
                state_d = StSettle;
            end
            StReload: begin
                cnt_d   = '0;
                state_d = StMove;
            end
            StMove: begin
                if (cnt_q == CW'(NTAPS - 2)) begin
                    state_d = StFinish;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFinish: begin
                for (int l = 0; l < L; l++) tap_out_d[l*TW +: TW] = centre[l];
                lane_fail_d = trk_fail;
                err_d       = |trk_fail;
                done_d      = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tap_q       <= '0;
            cnt_q       <= '0;
            bad_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lane_fail_q <= '0;
            tap_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lane_fail_q <= lane_fail_d;
            tap_out_q   <= tap_out_d;
        end
    end

    always_comb begin
        idelay_ce = '0;
        if (state_q == StStep)      idelay_ce = '1;
        else if (state_q == StMove) idelay_ce = move_ce;
    end

    assign idelay_inc = idelay_ce;
    assign idelay_ld  = (state_q == StLoad) || (state_q == StReload);
    assign busy       = state_q != StIdle;
    assign done       = done_q;
    assign err        = err_q;
    assign lane_fail  = lane_fail_q;
    assign tap_out    = tap_out_q;

endmodule
